// File: rtl/ff_puf_eval_ctrl.sv
// Feed-forward arbiter PUF evaluation controller: sequences clear/launch/sample per bit, majority-votes, steps an LFSR challenge.
// Latency: done RESP_W*(N_VOTE*(SETTLE+2)+1)+1 cycles after start is accepted (N_VOTE treated as 1 without PUF_VOTE_EN).
// Backpressure: none; start is only honoured in IDLE and ignored while busy. Optional feature macro: PUF_VOTE_EN.
module ff_puf_eval_ctrl #(
    parameter int              CH_W      = 8,
    parameter int              RESP_W    = 16,
    parameter int              N_VOTE    = 5,
    parameter int              SETTLE    = 4,
    parameter logic [CH_W-1:0] LFSR_POLY = CH_W'('hB8)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [CH_W-1:0]                 seed,
    output logic                            busy,
    output logic                            done,
    output logic [RESP_W-1:0]               resp,
    output logic [$clog2(RESP_W+1)-1:0]     unstable_cnt,
    output logic [CH_W-1:0]                 chal_out,
    output logic                            arb_clr,
    output logic                            launch,
    input  logic                            arb_bit
);

`ifdef PUF_VOTE_EN
    localparam int NV  = N_VOTE;
    localparam int VW  = $clog2(NV + 1);
`else
    // Voting compiled out: every bit is a single evaluation whatever N_VOTE says.
    localparam int NV  = N_VOTE / N_VOTE;
`endif
    localparam int UW  = $clog2(RESP_W + 1);
    localparam int VCW = (NV > 1) ? $clog2(NV) : 1;
    localparam int BW  = (RESP_W > 1) ? $clog2(RESP_W) : 1;
    localparam int SW  = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_LAUNCH,
        S_SAMPLE,
        S_RESOLVE,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [CH_W-1:0]     r_chal;
    logic [RESP_W-1:0]   r_work;
    logic [RESP_W-1:0]   r_resp;
    logic [BW-1:0]       r_bit;
    logic [VCW-1:0]      r_vote;
    logic [SW-1:0]       r_settle;

    logic                w_bit_val;
    logic [RESP_W-1:0]   w_work_nxt;
    logic [CH_W-1:0]     w_chal_step;

`ifdef PUF_VOTE_EN
    logic [VW-1:0]       r_ones;
    logic [UW-1:0]       r_unst_acc;
    logic [UW-1:0]       r_unst;
    logic                w_unstable;
`else
    logic                r_arb;
`endif

    // State register; reset wins over any start in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state sequencing and Moore-style strobes decoded from the current state.
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        arb_clr     = 1'b0;
        launch      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_CLR;
                end
            end
            S_CLR: begin
                busy        = 1'b1;
                arb_clr     = 1'b1;
                w_state_nxt = S_LAUNCH;
            end
            S_LAUNCH: begin
                busy   = 1'b1;
                launch = 1'b1;
                if (r_settle == SW'(SETTLE - 1)) begin
                    w_state_nxt = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                busy = 1'b1;
                if (r_vote == VCW'(NV - 1)) begin
                    w_state_nxt = S_RESOLVE;
                end else begin
                    w_state_nxt = S_CLR;
                end
            end
            S_RESOLVE: begin
                busy = 1'b1;
                if (r_bit == BW'(RESP_W - 1)) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_CLR;
                end
            end
            S_DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Bit decision for the current response position, the response with it inserted, and the next challenge.
    always_comb begin
`ifdef PUF_VOTE_EN
        w_bit_val  = (r_ones > VW'(NV / 2));
        w_unstable = (r_ones != '0) && (r_ones != VW'(NV));
`else
        w_bit_val  = r_arb;
`endif
        w_work_nxt        = r_work;
        w_work_nxt[r_bit] = w_bit_val;
        w_chal_step       = {r_chal[CH_W-2:0], ^(r_chal & LFSR_POLY)};
    end

    // Datapath: challenge LFSR, per-bit counters, vote tally and response assembly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_chal   <= '0;
            r_work   <= '0;
            r_resp   <= '0;
            r_bit    <= '0;
            r_vote   <= '0;
            r_settle <= '0;
`ifdef PUF_VOTE_EN
            r_ones     <= '0;
            r_unst_acc <= '0;
            r_unst     <= '0;
`else
            r_arb      <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        // An all-zero challenge would lock the LFSR, so it is replaced by 1.
                        r_chal   <= (seed == '0) ? CH_W'(1) : seed;
                        r_work   <= '0;
                        r_bit    <= '0;
                        r_vote   <= '0;
                        r_settle <= '0;
`ifdef PUF_VOTE_EN
                        r_ones     <= '0;
                        r_unst_acc <= '0;
`endif
                    end
                end
                S_CLR: begin
                    r_settle <= '0;
                end
                S_LAUNCH: begin
                    r_settle <= r_settle + SW'(1);
                end
                S_SAMPLE: begin
`ifdef PUF_VOTE_EN
                    r_ones <= r_ones + VW'(arb_bit);
`else
                    r_arb  <= arb_bit;
`endif
                    r_vote <= (r_vote == VCW'(NV - 1)) ? '0 : r_vote + VCW'(1);
                end
                S_RESOLVE: begin
                    r_work <= w_work_nxt;
                    r_chal <= w_chal_step;
                    r_bit  <= r_bit + BW'(1);
`ifdef PUF_VOTE_EN
                    r_ones     <= '0;
                    r_unst_acc <= r_unst_acc + UW'(w_unstable);
`endif
                    // Publish on the edge that enters DONE so resp changes together with the done pulse.
                    if (r_bit == BW'(RESP_W - 1)) begin
                        r_resp <= w_work_nxt;
`ifdef PUF_VOTE_EN
                        r_unst <= r_unst_acc + UW'(w_unstable);
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign resp     = r_resp;
    assign chal_out = r_chal;
`ifdef PUF_VOTE_EN
    assign unstable_cnt = r_unst;
`else
    assign unstable_cnt = '0;
`endif

endmodule

// File: tb/tb_ff_puf_eval_ctrl.sv
// Bench for ff_puf_eval_ctrl: table vectors, random patterns against a per-bit vote model, reset and start-while-busy sequences.
// Latency: expects done in the 497th cycle after accept (113 without PUF_VOTE_EN).
// Backpressure: none; the bench plays the arbiter chain, presenting one decision per clear strobe.
module tb_ff_puf_eval_ctrl;

    localparam int CH_W   = 8;
    localparam int RESP_W = 16;
    localparam int SETTLE = 4;
`ifdef PUF_VOTE_EN
    localparam int NV       = 5;
    localparam int EXP_DONE = 497;
    localparam int UNST_HI  = 16;
`else
    localparam int NV       = 1;
    localparam int EXP_DONE = 113;
    localparam int UNST_HI  = 0;
`endif
    localparam int NEV   = RESP_W * NV;
    localparam int LIMIT = 2 * EXP_DONE;

    localparam int K_ALL1   = 0;
    localparam int K_ALL0   = 1;
    localparam int K_11010  = 2;
    localparam int K_TOGGLE = 3;
    localparam int K_RAND   = 4;

    logic              clk;
    logic              rst;
    logic              start;
    logic [CH_W-1:0]   seed;
    logic              busy;
    logic              done;
    logic [RESP_W-1:0] resp;
    logic [4:0]        unstable_cnt;
    logic [CH_W-1:0]   chal_out;
    logic              arb_clr;
    logic              launch;
    logic              arb_bit;

    int n_checks = 0;
    int n_fail   = 0;

    logic arb_pat [0:NEV-1];

    typedef struct {
        logic [7:0]  seed;
        int          kind;
        logic [15:0] exp_resp;
        int          exp_unst;
        logic [7:0]  exp_chal0;
    } vec_t;

    vec_t tbl [4];

    ff_puf_eval_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .seed         (seed),
        .busy         (busy),
        .done         (done),
        .resp         (resp),
        .unstable_cnt (unstable_cnt),
        .chal_out     (chal_out),
        .arb_clr      (arb_clr),
        .launch       (launch),
        .arb_bit      (arb_bit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] lfsr_next(input logic [7:0] c);
        logic [7:0] t;
        t = c & 8'hB8;
        return {c[6:0], ^t};
    endfunction

    // Decision presented for evaluation g (bit g/NV, vote g%NV).
    task automatic fill_pat(input int kind);
        logic [4:0] p5;
        p5 = 5'b01011;
        for (int g = 0; g < NEV; g++) begin
            case (kind)
                K_ALL1:   arb_pat[g] = 1'b1;
                K_ALL0:   arb_pat[g] = 1'b0;
                K_11010:  arb_pat[g] = p5[(g % NV) % 5];
                K_TOGGLE: arb_pat[g] = ((g % 2) == 0);
                default:  arb_pat[g] = 1'($urandom_range(0, 1));
            endcase
        end
    endtask

    // Reference: majority over each bit's NV decisions; unstable when the votes disagree.
    task automatic model(output logic [15:0] m_resp, output int m_unst);
        int ones;
        m_resp = '0;
        m_unst = 0;
        for (int i = 0; i < RESP_W; i++) begin
            ones = 0;
            for (int j = 0; j < NV; j++) ones += int'(arb_pat[i*NV + j]);
            m_resp[i] = (2 * ones > NV);
            if (NV > 1 && ones != 0 && ones != NV) m_unst++;
        end
    endtask

    // One request: plays the arbiter chain, checks strobe shapes and challenge stepping, returns the results.
    task automatic run_req(input logic [7:0] sd, input bit poke,
                           output logic [15:0] got_resp, output int got_unst,
                           output int done_cyc, output logic [7:0] chal0);
        logic [7:0] exp_chal [0:RESP_W];
        int ev, cyc, lw, bad_lw, bad_chal, extra;
        logic [7:0] fin_chal;
        exp_chal[0] = (sd == 8'h00) ? 8'h01 : sd;
        for (int i = 1; i <= RESP_W; i++) exp_chal[i] = lfsr_next(exp_chal[i-1]);
        got_resp = '0; got_unst = -1; done_cyc = -1; chal0 = 'x; fin_chal = 'x;
        ev = 0; lw = 0; bad_lw = 0; bad_chal = 0; extra = 0;
        seed  = sd;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        chk("busy_after_accept", busy, 1'b1);
        while (cyc <= LIMIT) begin
            start = poke && (cyc == 50);
            if (arb_clr) begin
                if (ev == 0) chal0 = chal_out;
                if (ev >= NEV || chal_out !== exp_chal[ev / NV]) bad_chal++;
                if (ev < NEV) arb_bit = arb_pat[ev];
                ev++;
            end
            if (arb_clr && launch) bad_lw++;
            if (launch) begin
                if (ev == 0 || ev > NEV || chal_out !== exp_chal[(ev - 1) / NV]) bad_chal++;
                lw++;
            end else if (lw != 0) begin
                if (lw != SETTLE) bad_lw++;
                lw = 0;
            end
            if (done) begin
                done_cyc = cyc;
                got_resp = resp;
                got_unst = int'(unstable_cnt);
                fin_chal = chal_out;
                if (!busy) bad_lw++;
                start = poke;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        if (done_cyc < 0) chk("done_timeout", 1'b0, 1'b1);
        chk("eval_count", ev, NEV);
        chk("chal_per_bit", bad_chal, 0);
        chk("strobe_shape", bad_lw, 0);
        chk("chal_after_16_steps", fin_chal, exp_chal[RESP_W]);
        @(negedge clk);
        start = 1'b0;
        chk("idle_after_done", {busy, done}, 2'b00);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        chk("single_done", extra, 0);
        chk("resp_hold", resp, got_resp);
    endtask

    initial begin
        logic [15:0] r, m_resp;
        int u, dc, m_unst;
        logic [7:0] c0, sd;

        rst = 1'b1; start = 1'b0; seed = '0; arb_bit = 1'b0;

        tbl[0] = '{8'h01, K_ALL1,   16'hFFFF, 0,       8'h01};
        tbl[1] = '{8'h00, K_ALL0,   16'h0000, 0,       8'h01};
        tbl[2] = '{8'h5A, K_11010,  16'hFFFF, UNST_HI, 8'h5A};
        tbl[3] = '{8'h01, K_TOGGLE, 16'h5555, UNST_HI, 8'h01};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_strobes", {arb_clr, launch}, 2'b00);
        chk("rst_resp", resp, 16'h0000);
        chk("rst_unst", unstable_cnt, 5'd0);
        chk("rst_chal", chal_out, 8'h00);
        rst = 1'b0;
        @(negedge clk);

        for (int t = 0; t < 4; t++) begin
            fill_pat(tbl[t].kind);
            run_req(tbl[t].seed, 1'b0, r, u, dc, c0);
            chk("tbl_resp", r, tbl[t].exp_resp);
            chk("tbl_unst", u, tbl[t].exp_unst);
            chk("tbl_done_cycle", dc, EXP_DONE);
            chk("tbl_first_chal", c0, tbl[t].exp_chal0);
        end

        for (int t = 0; t < 4; t++) begin
            sd = 8'($urandom);
            fill_pat(K_RAND);
            model(m_resp, m_unst);
            run_req(sd, 1'b0, r, u, dc, c0);
            chk("rand_resp", r, m_resp);
            chk("rand_unst", u, m_unst);
            chk("rand_done_cycle", dc, EXP_DONE);
        end

        // start pulsed mid-request and again on the done cycle: both must be ignored.
        fill_pat(K_TOGGLE);
        run_req(8'h33, 1'b1, r, u, dc, c0);
        chk("poke_done_cycle", dc, EXP_DONE);
        chk("poke_resp", r, 16'h5555);

        // Reset 100 cycles into a request, with start asserted alongside it.
        fill_pat(K_ALL1);
        seed = 8'h77;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (99) @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        chk("midrst_busy_done", {busy, done}, 2'b00);
        chk("midrst_strobes", {arb_clr, launch}, 2'b00);
        chk("midrst_resp", resp, 16'h0000);
        chk("midrst_unst", unstable_cnt, 5'd0);
        chk("midrst_chal", chal_out, 8'h00);
        repeat (3) @(negedge clk);
        chk("midrst_start_ignored", busy, 1'b0);
        fill_pat(K_11010);
        run_req(8'h00, 1'b0, r, u, dc, c0);
        chk("post_rst_resp", r, 16'hFFFF);
        chk("post_rst_unst", u, UNST_HI);
        chk("post_rst_done_cycle", dc, EXP_DONE);
        chk("post_rst_first_chal", c0, 8'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ff_puf_eval_ctrl.md
FF_PUF_EVAL_CTRL -- requirements
Module: ff_puf_eval_ctrl

Interface
REQ-001 SHALL have parameter CH_W, default 8, meaning challenge / LFSR width (4..32).
REQ-002 SHALL have parameter RESP_W, default 16, meaning response bits per request (1..64).
REQ-003 SHALL have parameter N_VOTE, default 5, meaning evaluations per response bit (odd, 1..15).
REQ-004 SHALL have parameter SETTLE, default 4, meaning launch-to-sample cycles (>=1).
REQ-005 SHALL have parameter LFSR_POLY, default 8'hB8 (CH_W bits), meaning LFSR feedback tap mask.
REQ-006 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-007 SHALL have port rst  input  1  synchronous active-high reset.
REQ-008 SHALL have port start  input  1  request pulse, sampled only in IDLE.
REQ-009 SHALL have port seed  input  CH_W  initial challenge, captured with start.
REQ-010 SHALL have port busy  output  1  high from the cycle after start acceptance through the done cycle.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port resp  output  RESP_W  assembled response, held until next done.
REQ-013 SHALL have port unstable_cnt  output  clog2(RESP_W+1)  count of non-unanimous bits in resp.
REQ-014 SHALL have port chal_out  output  CH_W  challenge driven to the external feed-forward arbiter chain.
REQ-015 SHALL have port arb_clr  output  1  arbiter flip-flop clear strobe.
REQ-016 SHALL have port launch  output  1  chain input edge (mux_in) drive.
REQ-017 SHALL have port arb_bit  input  1  arbiter decision from the chain.

Function
REQ-018 SHALL implement FSM IDLE -> CLR -> LAUNCH -> SAMPLE -> (CLR if votes remain, else RESOLVE) -> (CLR if bits remain, else DONE) -> IDLE.
REQ-019 SHALL in IDLE with start=1 capture seed into chal_out, substituting 1 for an all-zero seed, and clear vote, bit and unstable counters.
REQ-020 SHALL assert arb_clr for exactly one cycle in CLR, with launch low.
REQ-021 SHALL hold launch high for exactly SETTLE cycles in LAUNCH, then drop it in SAMPLE.
REQ-022 SHALL register arb_bit in SAMPLE and increment the ones-counter when it is 1.
REQ-023 SHALL in RESOLVE write bit i (i = 0 first) as 1 iff ones > N_VOTE/2, increment unstable when 0 < ones < N_VOTE, clear ones, and step the LFSR: chal <= {chal[CH_W-2:0], ^(chal & LFSR_POLY)}.
REQ-024 SHALL keep chal_out stable during all CLR/LAUNCH/SAMPLE cycles of one bit.
REQ-025 SHALL update resp and unstable_cnt only in DONE, simultaneously with the done pulse.
REQ-026 SHALL produce done exactly RESP_W*(N_VOTE*(SETTLE+2)+1)+1 cycles after the start-accept edge.
REQ-027 SHALL ignore start while busy, including in the DONE cycle; a start in the following IDLE cycle is accepted.

Reset
REQ-028 SHALL on rst=1 at any clock edge, including mid-operation, enter IDLE and drive busy=0, done=0, arb_clr=0, launch=0, resp=0, unstable_cnt=0, chal_out=0.
REQ-029 SHALL give rst priority over start in the same cycle.

Configuration
REQ-030 SHALL compile majority voting in only when PUF_VOTE_EN is defined, with behaviour per REQ-022/023/026.
REQ-031 SHALL without PUF_VOTE_EN evaluate each bit once (effective N_VOTE=1), set resp bit = sampled arb_bit, tie unstable_cnt to 0, and produce done after RESP_W*(SETTLE+3)+1 cycles.

Verification
REQ-032 SHALL cover defaults with PUF_VOTE_EN defined, seed=8'h01, arb_bit held at 1 -> done at cycle 497, resp=16'hFFFF, unstable_cnt=0.
REQ-033 SHALL cover seed=8'h00, arb_bit=0 -> first chal_out=8'h01, resp=0, LFSR sequence matching the reference model for 16 steps.
REQ-034 SHALL cover arb_bit pattern 1,1,0,1,0 per bit (defaults) -> every resp bit=1, unstable_cnt=16.
REQ-035 SHALL cover rst asserted 100 cycles after start -> next cycle IDLE, all outputs 0, and a new start completing normally.
REQ-036 SHALL cover start pulsed during busy and on the done cycle -> ignored, with exactly one done per accepted start.
REQ-037 SHALL cover PUF_VOTE_EN undefined, defaults, with arb_bit toggling every SAMPLE -> done at cycle 113, resp=16'h5555, unstable_cnt=0.
